gpio_config_shifter: RTL

GPIO_CONFIG_SHIFTER -- requirements
Module: gpio_config_shifter

---
 rtl/gpio_config_shifter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/gpio_config_shifter.sv
// Serial pad-configuration chain driver: shifts one CFG_BITS word per pad, MSB first, then latches.
// Optional macro GPIO_CFG_SPLIT_CHAIN_EN splits the pads into two chains shifted in parallel.
module gpio_config_shifter #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    parameter int CLK_DIV  = 2
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        start,
    output logic [$clog2(NUM_PADS)-1:0] cfg_rd_addr,
    input  logic [CFG_BITS-1:0]         cfg_rd_data,
`ifdef GPIO_CFG_SPLIT_CHAIN_EN
    output logic                        serial_data_out_2,
    output logic [$clog2(NUM_PADS)-1:0] cfg_rd_addr_2,
    input  logic [CFG_BITS-1:0]         cfg_rd_data_2,
`endif
    output logic                        serial_clock,
    output logic                        serial_data_out,
    output logic                        serial_load,
    output logic                        busy,
    output logic                        done
);

    localparam int AW = $clog2(NUM_PADS);
    localparam int BW = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
`ifdef GPIO_CFG_SPLIT_CHAIN_EN
    localparam int CHAIN_PADS = NUM_PADS / 2;
`else
    localparam int CHAIN_PADS = NUM_PADS;
`endif
    localparam logic [AW-1:0] LAST_PAD = AW'(CHAIN_PADS - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(CFG_BITS - 1);
    localparam logic [PW-1:0] LAST_PH  = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT_LO,
        S_SHIFT_HI,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [AW-1:0]   r_pad;
    logic [BW-1:0]   r_bit;
    logic [PW-1:0]   r_ph;
    logic            r_sclk;
    logic            r_hold;
    logic            r_load;
    logic            r_busy;
    logic            r_done;
    logic            w_phase_end;
    logic            w_bit;

    assign w_phase_end = (r_ph == LAST_PH);
    assign w_bit       = cfg_rd_data[r_bit];

    // Data is presented straight from the read port in the low phase and
    // frozen for the high phase so the pad chain sees a stable bit at the rise.
    assign serial_data_out = (r_state == S_SHIFT_LO) ? w_bit : r_hold;
    assign cfg_rd_addr     = r_pad;
    assign serial_clock    = r_sclk;
    assign serial_load     = r_load;
    assign busy            = r_busy;
    assign done            = r_done;

`ifdef GPIO_CFG_SPLIT_CHAIN_EN
    logic r_hold_2;
    logic w_bit_2;

    assign w_bit_2           = cfg_rd_data_2[r_bit];
    assign serial_data_out_2 = (r_state == S_SHIFT_LO) ? w_bit_2 : r_hold_2;
    assign cfg_rd_addr_2     = r_pad + AW'(CHAIN_PADS);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_hold_2 <= 1'b0;
        end else if (r_state == S_SHIFT_LO) begin
            r_hold_2 <= w_bit_2;
        end else if (r_state != S_SHIFT_HI) begin
            r_hold_2 <= 1'b0;
        end
    end
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state <= S_IDLE;
            r_pad   <= '0;
            r_bit   <= '0;
            r_ph    <= '0;
            r_sclk  <= 1'b0;
            r_hold  <= 1'b0;
            r_load  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_hold <= 1'b0;
                    if (start) begin
                        r_state <= S_SHIFT_LO;
                        r_pad   <= LAST_PAD;
                        r_bit   <= LAST_BIT;
                        r_ph    <= '0;
                        r_sclk  <= 1'b0;
                        r_busy  <= 1'b1;
                    end
                end
                S_SHIFT_LO: begin
                    r_hold <= w_bit;
                    if (w_phase_end) begin
                        r_ph    <= '0;
                        r_sclk  <= 1'b1;
                        r_state <= S_SHIFT_HI;
                    end else begin
                        r_ph <= r_ph + PW'(1);
                    end
                end
                S_SHIFT_HI: begin
                    if (w_phase_end) begin
                        r_ph   <= '0;
                        r_sclk <= 1'b0;
                        if (r_bit != '0) begin
                            r_bit   <= r_bit - BW'(1);
                            r_state <= S_SHIFT_LO;
                        end else if (r_pad != '0) begin
                            r_bit   <= LAST_BIT;
                            r_pad   <= r_pad - AW'(1);
                            r_state <= S_SHIFT_LO;
                        end else begin
                            r_hold  <= 1'b0;
                            r_load  <= 1'b1;
                            r_state <= S_LOAD;
                        end
                    end else begin
                        r_ph <= r_ph + PW'(1);
                    end
                end
                S_LOAD: begin
                    if (w_phase_end) begin
                        r_ph    <= '0;
                        r_load  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_ph <= r_ph + PW'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
